// File: rtl/op_dispatcher_if.sv
// Host byte stream and engine op handshakes for op_dispatcher.
// master: host/engine side; slave: the dispatcher.
interface op_dispatcher_if;
    logic [7:0]   in_byte;
    logic         in_rts;
    logic         in_rtr;
    logic [127:0] line_op;
    logic         line_rts;
    logic         line_rtr;
    logic [127:0] circ_op;
    logic         circ_rts;
    logic         circ_rtr;
    logic [7:0]   drop_cnt;
    logic         busy;

    modport master (
        output in_byte,
        output in_rts,
        input  in_rtr,
        input  line_op,
        input  line_rts,
        output line_rtr,
        input  circ_op,
        input  circ_rts,
        output circ_rtr,
        input  drop_cnt,
        input  busy
    );

    modport slave (
        input  in_byte,
        input  in_rts,
        output in_rtr,
        output line_op,
        output line_rts,
        input  line_rtr,
        output circ_op,
        output circ_rts,
        input  circ_rtr,
        output drop_cnt,
        output busy
    );
endinterface

// File: rtl/op_dispatcher.sv
// Assembles 16 host bytes into a 128-bit op and hands it to the
// line (opcode 0x01) or circle (opcode 0x02) engine; others dropped.
// Ports: clk, rst_ (async active-low), bus (op_dispatcher_if.slave):
//   in_byte/in_rts/in_rtr host stream, line_*/circ_* engine outputs,
//   drop_cnt saturating discard count, busy partial op or dispatch.
// Optional macro CMD_TIMEOUT_EN: drops a partial op that has been
// idle for TIMEOUT_CYCLES cycles.
module op_dispatcher #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_LOG2   = 10
) (
    input  logic            clk,
    input  logic            rst_,
    op_dispatcher_if.slave  bus
);
    typedef enum logic {
        ASSEMBLE,
        DISPATCH
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_byte_cnt;
    logic [3:0]   w_byte_cnt_nxt;
    logic [127:0] r_op;
    logic [127:0] w_op_nxt;
    logic [7:0]   r_drop;
    logic [7:0]   w_drop_nxt;
    logic [7:0]   w_drop_inc;
    logic [7:0]   w_opcode;
    logic         w_in_xfer;
    logic         w_is_line;
    logic         w_is_circ;
    logic         w_out_xfer;
    logic         w_timeout;

    assign w_opcode   = r_op[127:120];
    assign w_in_xfer  = (r_state == ASSEMBLE) && bus.in_rts;
    assign w_is_line  = (r_state == DISPATCH) && (w_opcode == 8'h01);
    assign w_is_circ  = (r_state == DISPATCH) && (w_opcode == 8'h02);
    assign w_out_xfer = (w_is_line && bus.line_rtr) ||
                        (w_is_circ && bus.circ_rtr);
    assign w_drop_inc = (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;

`ifdef CMD_TIMEOUT_EN
    localparam logic [TIMEOUT_LOG2-1:0] LP_IDLE_MAX =
        TIMEOUT_LOG2'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_LOG2-1:0] r_idle;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle edge.
    assign w_timeout = (r_state == ASSEMBLE) &&
                       (r_byte_cnt != 4'd0) &&
                       !w_in_xfer &&
                       (r_idle == LP_IDLE_MAX);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_idle <= '0;
        end else if ((r_state != ASSEMBLE) ||
                     (r_byte_cnt == 4'd0) ||
                     w_in_xfer || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    // Timeout parameters only matter when the counter is built in.
    assign w_timeout = (TIMEOUT_CYCLES < 0) && (TIMEOUT_LOG2 < 0);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_op_nxt       = r_op;
        w_drop_nxt     = r_drop;
        unique case (r_state)
            ASSEMBLE: begin
                if (w_in_xfer) begin
                    w_op_nxt[{r_byte_cnt, 3'b000} +: 8] = bus.in_byte;
                    w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'd15) begin
                        w_state_nxt = DISPATCH;
                    end
                end else if (w_timeout) begin
                    w_byte_cnt_nxt = 4'd0;
                    w_drop_nxt     = w_drop_inc;
                end
            end
            DISPATCH: begin
                if (w_is_line || w_is_circ) begin
                    if (w_out_xfer) begin
                        w_state_nxt = ASSEMBLE;
                    end
                end else begin
                    w_drop_nxt  = w_drop_inc;
                    w_state_nxt = ASSEMBLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= ASSEMBLE;
            r_byte_cnt <= 4'd0;
            r_op       <= '0;
            r_drop     <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_op       <= w_op_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    assign bus.in_rtr   = (r_state == ASSEMBLE);
    assign bus.line_op  = r_op;
    assign bus.circ_op  = r_op;
    assign bus.line_rts = w_is_line;
    assign bus.circ_rts = w_is_circ;
    assign bus.drop_cnt = r_drop;
    assign bus.busy     = (r_byte_cnt != 4'd0) ||
                          (r_state == DISPATCH);
endmodule
